// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encodings, FSM state encodings and constants for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_TIMES  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALUOP_TIMESU = 4'd9;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV    = 4'd10;
  localparam logic [ALUOP_W-1:0] ALUOP_DIVU   = 4'd11;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'd0,
    MULDIV_ST_CALC = 2'd1,
    MULDIV_ST_FIX  = 2'd2
  } muldiv_state_e;

  localparam int          MULDIV_ITERS     = 32;
  localparam logic [31:0] MULDIV_DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic muldiv_op_valid(input logic [ALUOP_W-1:0] op_sel);
    return (op_sel == ALUOP_TIMES) || (op_sel == ALUOP_TIMESU) ||
           (op_sel == ALUOP_DIV)   || (op_sel == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO and flush handled here.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (IDLE -> FIX, latency 2).
//
// state | meaning
// IDLE  | accepts start and MTHI/MTLO writes
// CALC  | one shift-add or restoring-divide iteration per cycle
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ALUOP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  input  logic               writeHi,
  input  logic               writeLo,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  muldiv_state_e      state_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_mul_q, neg_q, rneg_q, div0_q, busy_q, done_q;

  logic               is_signed, is_mul_op, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   rem_new, quot_fix, rem_fix;
  logic               q_bit;

  always_comb begin
    is_signed = (op == ALUOP_TIMES) || (op == ALUOP_DIV);
    is_mul_op = (op == ALUOP_TIMES) || (op == ALUOP_TIMESU);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
  end

  // Multiply keeps the multiplier in the low half and shifts the running sum in from the top.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (rem_new),
    .q_o       (q_bit)
  );

  always_comb begin
    div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};
    prod_fix = neg_q ? -acc_q : acc_q;
    rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Signed divide by zero would otherwise get its all-ones quotient negated.
    if (div0_q) quot_fix = WIDTH'(MULDIV_DIV0_QUOT);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MULDIV_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MULDIV_ST_IDLE: begin
          if (writeHi) hi_q <= a;
          if (writeLo) lo_q <= a;
          if (start && !cancel && muldiv_op_valid(op)) begin
            is_mul_q <= is_mul_op;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            div0_q   <= !is_mul_op && (b == '0);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            opnd_q   <= is_mul_op ? mag_a : mag_b;
            acc_q    <= {{WIDTH{1'b0}}, is_mul_op ? mag_b : mag_a};
            state_q  <= MULDIV_ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul_op) begin
              acc_q   <= fast_prod;
              state_q <= MULDIV_ST_FIX;
            end
`endif
          end
        end
        MULDIV_ST_CALC: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= MULDIV_ST_IDLE;
          end else begin
            acc_q <= is_mul_q ? mul_next : div_next;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(MULDIV_ITERS - 1)) state_q <= MULDIV_ST_FIX;
          end
        end
        MULDIV_ST_FIX: begin
          busy_q  <= 1'b0;
          state_q <= MULDIV_ST_IDLE;
          if (!cancel) begin
            done_q <= 1'b1;
            if (is_mul_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= MULDIV_ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic vectors, latency, flush, reset and HI/LO writes.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  typedef struct {
    logic [ALUOP_W-1:0] op;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst, start, cancel, writeHi, writeLo;
  logic [ALUOP_W-1:0] op;
  logic [W-1:0]       a, b;
  logic               busy, done;
  logic [W-1:0]       hi, lo;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .writeHi(writeHi), .writeLo(writeLo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic exp_t model(input logic [ALUOP_W-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] p, q, r;
    e.lat = DIV_LAT;
    p = '0; q = '0; r = '0;
    if (o == ALUOP_TIMES) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.lat = MUL_LAT;
    end else if (o == ALUOP_TIMESU) begin
      p = {32'b0, x} * {32'b0, y};
      e.lat = MUL_LAT;
    end else if (y == 0) begin
      q = 64'h0000_0000_FFFF_FFFF;
      r = {32'b0, x};
    end else if (o == ALUOP_DIV) begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
    end else begin
      q = {32'b0, x} / {32'b0, y};
      r = {32'b0, x} % {32'b0, y};
    end
    if (o == ALUOP_TIMES || o == ALUOP_TIMESU) begin
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (or after the budget).
  task automatic run_op(input logic [ALUOP_W-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; cancel = 0; writeHi = 0; writeLo = 0;
    op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) $display("FAIL reset busy=%0b done=%0b hi=%h lo=%h required all zero", busy, done, hi, lo);
    else n_pass++;
  endtask

  task automatic test_vectors();
    vec_t vt[7];
    exp_t e;
    int   lat;
    vt[0] = '{ALUOP_TIMESU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1] = '{ALUOP_TIMES,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[2] = '{ALUOP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{ALUOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[4] = '{ALUOP_DIVU,   32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vt[5] = '{ALUOP_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[6] = '{ALUOP_DIVU,   32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{vt[i].hi, vt[i].lo,
                     (vt[i].op == ALUOP_TIMES || vt[i].op == ALUOP_TIMESU) ? MUL_LAT : DIV_LAT});
      run_op(vt[i].op, vt[i].a, vt[i].b, lat);
      e = sb.pop_front();
      n_total++;
      if (lat !== e.lat) $display("FAIL vec%0d latency got %0d required %0d", i, lat, e.lat);
      else n_pass++;
      n_total++;
      if (hi !== e.hi) $display("FAIL vec%0d hi got %h required %h", i, hi, e.hi);
      else n_pass++;
      n_total++;
      if (lo !== e.lo) $display("FAIL vec%0d lo got %h required %h", i, lo, e.lo);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [ALUOP_W-1:0] ops[4];
    logic [ALUOP_W-1:0] o;
    logic [W-1:0]       x, y;
    exp_t               e;
    int                 lat;
    ops[0] = ALUOP_TIMES; ops[1] = ALUOP_TIMESU; ops[2] = ALUOP_DIV; ops[3] = ALUOP_DIVU;
    for (int i = 0; i < 12; i++) begin
      o = ops[i % 4];
      x = $urandom;
      y = (i % 5 == 4) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      sb.push_back(model(o, x, y));
      run_op(o, x, y, lat);
      e = sb.pop_front();
      n_total++;
      if (lat !== e.lat || hi !== e.hi || lo !== e.lo)
        $display("FAIL rand%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h",
                 i, o, x, y, lat, hi, lo, e.lat, e.hi, e.lo);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    logic seen;
    a = 32'h11; writeHi = 1'b1;
    @(negedge clk);
    writeHi = 1'b0; a = 32'h22; writeLo = 1'b1;
    @(negedge clk);
    writeLo = 1'b0;
    start = 1'b1; op = ALUOP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL cancel_busy_before got %0b required 1", busy);
    else n_pass++;
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL cancel_busy_after got %0b required 0", busy);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL cancel_no_done got done=%0b required 0", seen);
    else n_pass++;
    n_total++;
    if (hi !== 32'h11 || lo !== 32'h22) $display("FAIL cancel_hilo got hi=%h lo=%h required hi=11 lo=22", hi, lo);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   lat;
    logic seen;
    sb.push_back(model(ALUOP_DIVU, 32'd1000, 32'd7));
    start = 1'b1; op = ALUOP_DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      if (lat == 5) begin
        start = 1'b1; op = ALUOP_TIMESU; a = 32'd5; b = 32'd5;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || hi !== e.hi || lo !== e.lo)
      $display("FAIL busy_ignore got lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h", lat, hi, lo, e.lat, e.hi, e.lo);
    else n_pass++;
    @(negedge clk);
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL busy_ignore_queued got activity=%0b required 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    start = 1'b1; op = ALUOP_TIMES; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) $display("FAIL reset_mid busy=%0b done=%0b hi=%h lo=%h required all zero", busy, done, hi, lo);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_mid_no_done got done=%0b required 0", seen);
    else n_pass++;
  endtask

  task automatic test_writes();
    exp_t e;
    int   lat;
    logic seen;
    a = 32'h5A; writeLo = 1'b1;
    @(negedge clk);
    writeLo = 1'b0;
    n_total++;
    if (lo !== 32'h5A) $display("FAIL mtlo got %h required 0000005a", lo);
    else n_pass++;
    start = 1'b1; cancel = 1'b1; writeHi = 1'b1; op = ALUOP_DIVU; a = 32'h77; b = 32'h3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; writeHi = 1'b0;
    n_total++;
    if (busy !== 1'b0 || hi !== 32'h77) $display("FAIL cancel_start_write got busy=%0b hi=%h required busy=0 hi=00000077", busy, hi);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL cancel_start_no_done got done=%0b required 0", seen);
    else n_pass++;
    sb.push_back('{32'h64, 32'hFFFF_FFFF, DIV_LAT});
    writeLo = 1'b1;
    start = 1'b1; op = ALUOP_DIVU; a = 32'h64; b = 32'h0;
    @(negedge clk);
    start = 1'b0; writeLo = 1'b0;
    n_total++;
    if (lo !== 32'h64 || busy !== 1'b1) $display("FAIL start_with_mtlo got lo=%h busy=%0b required lo=00000064 busy=1", lo, busy);
    else n_pass++;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || hi !== e.hi || lo !== e.lo)
      $display("FAIL start_with_mtlo_result got lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h", lat, hi, lo, e.lat, e.hi, e.lo);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    sb.push_back(model(ALUOP_DIV, 32'hFFFF_FF00, 32'd10));
    sb.push_back(model(ALUOP_TIMESU, 32'h0001_0000, 32'h0001_0000));
    run_op(ALUOP_DIV, 32'hFFFF_FF00, 32'd10, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || hi !== e.hi || lo !== e.lo)
      $display("FAIL b2b_first got lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h", lat, hi, lo, e.lat, e.hi, e.lo);
    else n_pass++;
    run_op(ALUOP_TIMESU, 32'h0001_0000, 32'h0001_0000, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat || hi !== e.hi || lo !== e.lo)
      $display("FAIL b2b_second got lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h", lat, hi, lo, e.lat, e.hi, e.lo);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_one_cycle got done=%0b busy=%0b required 0 0", done, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_cancel();
    test_busy_ignore();
    test_reset_mid();
    test_writes();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair and sequences the MULT/MULTU/DIV/DIVU operations decoded by the instruction controller. It sits beside the ALU in the execute stage. It accepts one operation at a time, holds `busy` so the pipeline stalls MFHI/MFLO and further mul/div issue, and writes HI/LO when the operation completes. It also serves MTHI/MTLO writes and exception-flush cancellation.

## Interface
Parameters:
- `WIDTH`, default 32. Operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`, input, 1. The single clock; all state updates on the rising edge.
- `rst`, input, 1. Synchronous, active-high reset.
- `start`, input, 1. Issue request; accepted only in IDLE.
- `op`, input, `ALUOP. Operation select. Valid values are `ALUOP_TIMES`, `ALUOP_TIMESU`, `ALUOP_DIV`, `ALUOP_DIVU`. Any other value with `start` is ignored.
- `a`, input, WIDTH. rs operand (dividend / multiplicand).
- `b`, input, WIDTH. rt operand (divisor / multiplier).
- `cancel`, input, 1. Flush; aborts the in-flight operation.
- `writeHi`, input, 1. MTHI write enable, data from `a`.
- `writeLo`, input, 1. MTLO write enable, data from `a`.
- `busy`, output, 1. Operation in flight.
- `done`, output, 1. One-cycle completion pulse.
- `hi`, output, WIDTH. HI register.
- `lo`, output, WIDTH. LO register.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start` with a valid op: latch operand magnitudes, result-sign flags and op; clear the 6-bit iteration counter; go to CALC.
- **CALC**
  - Performs one iteration per cycle:
    - multiply is shift-add;
    - divide is restoring, one quotient bit per cycle.
  - After 32 iterations (counter == 31), go to FIX.
- **FIX**
  - Apply sign correction and write HI/LO, then go to IDLE.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Signed divide: quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
- Arithmetic: signed ops use the magnitudes of the operands, computed mod 2^32.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Divide by zero, both DIV and DIVU: lo = 0xFFFFFFFF, hi = a.
  - Still takes the full latency; no exception is raised.
- MTHI/MTLO:
  - Applied in IDLE only; ignored while `busy` (the pipeline guarantees a stall).
  - If `start` and a write occur in the same cycle, both take effect; the later result overwrites HI/LO.
- `cancel`:
  - From CALC or FIX, go to IDLE next cycle.
  - HI/LO are unchanged and no `done` is produced.
  - `cancel` together with `start` in IDLE: cancel wins, start is ignored. A write in that cycle still applies.
- `start` while `busy`: ignored, with no queueing.
- Reset: state IDLE; `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0.
  - Reset mid-operation discards the operation.

## Timing
- `start` is sampled in cycle 0. Cycles 1–32 are CALC and cycle 33 is FIX. HI/LO update at the end of cycle 33.
- Cycle 34: `busy` = 0, `done` = 1, and `hi`/`lo` show the result. Latency from start to done is 34 cycles.
- `busy` is registered: high in cycles 1–33 and low in the cycle `start` is sampled.
- `done` is registered and high exactly one cycle. A new `start` may be accepted in the `done` cycle.
- HI/LO writes from MTHI/MTLO are visible the next cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU skip CALC; the product is computed with a single-cycle `*` and the unit goes IDLE→FIX.
  - `busy` is high in cycle 1 only; `done` is high in cycle 2. Multiply latency is 2.
- Not defined: multiply uses the iterative path with 34-cycle latency.
- Divide behaviour is identical either way.

## Structure
- Opcode encodings reuse the existing `ALUOP` definitions in `ALUOp.vh`.
- Add `MulDiv.vh` holding:
  - the state encodings `MULDIV_ST_IDLE`/`CALC`/`FIX`;
  - the iteration count (32);
  - the divide-by-zero quotient constant.
- The FSM, counter, sign handling and HI/LO live in `muldiv_unit`.
- One sub-module, `muldiv_div_step`: a combinational restoring-division step taking partial remainder, dividend bit and divisor, and returning the new remainder and quotient bit.

## Test plan
- MULTU with a = b = 0xFFFFFFFF: `done` at cycle 34 (cycle 2 with the macro); hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT with a = 0xFFFFFFFD (−3), b = 7: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV with a = 0xFFFFFFF9 (−7), b = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV with a = 0x80000000, b = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU with a = 100, b = 0: lo = 0xFFFFFFFF, hi = 0x64.
- Control-path checks:
  - With HI/LO = 0x11/0x22, DIVU starts and `cancel` is asserted at cycle 10: `busy` = 0 at cycle 11, no `done`, HI/LO unchanged.
  - A second `start` at cycle 5 is ignored.
  - `rst` at cycle 20 clears everything.
  - `writeLo` in IDLE with a = 0x5A: lo = 0x5A next cycle.
